// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, waits out ROM latency, latches the
// instruction and hands it to decode over valid/ready, with redirect and halt.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          PC_STEP   = 4,
  parameter int          MEM_LAT   = 1,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        i_clk,
  input  logic        i_reset,
  output logic [31:0] o_mem_addr,
  input  logic [31:0] i_mem_rdata,
  output logic [31:0] o_inst,
  output logic        o_inst_valid,
  input  logic        i_inst_ready,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic [31:0] o_pc,
  output logic        o_halt,
  output logic [15:0] o_fetch_count
);

  localparam logic [3:0]  LAT  = 4'(MEM_LAT);
  localparam logic [31:0] STEP = 32'(PC_STEP);

  typedef enum logic [1:0] {S_WAIT, S_HOLD, S_HALTED} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [3:0]  r_wcnt, w_wcnt_nxt;
  logic [31:0] r_inst, w_inst_nxt;
  logic        r_valid, w_valid_nxt;
  logic        r_halt, w_halt_nxt;
  logic [15:0] r_count, w_count_nxt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_WAIT;
      r_pc    <= RESET_PC;
      r_wcnt  <= LAT;
      r_inst  <= 32'h0;
      r_valid <= 1'b0;
      r_halt  <= 1'b0;
      r_count <= 16'h0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_inst  <= w_inst_nxt;
      r_valid <= w_valid_nxt;
      r_halt  <= w_halt_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_wcnt_nxt  = r_wcnt;
    w_inst_nxt  = r_inst;
    w_valid_nxt = r_valid;
    w_halt_nxt  = r_halt;
    w_count_nxt = r_count;
    // Redirect wins in every state; a coincident accept in HOLD is dropped.
    if (i_redirect) begin
      w_pc_nxt    = {i_redirect_pc[31:2], 2'b00};
      w_valid_nxt = 1'b0;
      w_halt_nxt  = 1'b0;
      w_wcnt_nxt  = LAT;
      w_state_nxt = S_WAIT;
    end else begin
      case (r_state)
        S_WAIT: begin
          if (r_wcnt != 4'd0) begin
            w_wcnt_nxt = r_wcnt - 4'd1;
          end else if (i_mem_rdata == HALT_WORD) begin
            w_halt_nxt  = 1'b1;
            w_state_nxt = S_HALTED;
          end else begin
            w_inst_nxt  = i_mem_rdata;
            w_valid_nxt = 1'b1;
            w_state_nxt = S_HOLD;
          end
        end
        S_HOLD: begin
          if (i_inst_ready) begin
            w_pc_nxt    = r_pc + STEP;
            w_count_nxt = r_count + 16'd1;
            w_valid_nxt = 1'b0;
            w_wcnt_nxt  = LAT;
            w_state_nxt = S_WAIT;
          end
        end
        S_HALTED: ;
        default: w_state_nxt = S_WAIT;
      endcase
    end
  end

  assign o_mem_addr    = r_pc;
  assign o_pc          = r_pc;
  assign o_inst        = r_inst;
  assign o_inst_valid  = r_valid;
  assign o_halt        = r_halt;
  assign o_fetch_count = r_count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus a randomized run checked
// against a timestamp-based transaction model of the fetch rules.
module tb_fetch_sequencer;

  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        reset, redirect, inst_ready;
  logic [31:0] redirect_pc;
  logic [31:0] mem_addr, mem_rdata, inst, pc;
  logic        inst_valid, halt;
  logic [15:0] fetch_count;

  logic        reset0;
  logic [31:0] mem_addr0, mem_rdata0, inst0, pc0;
  logic        inst_valid0, halt0;
  logic [15:0] fetch_count0;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model state
  int          e = 0;
  int          m_ready_at = 0;
  logic [31:0] m_pc = 32'h0, m_inst = 32'h0;
  logic        m_valid = 1'b0, m_halt = 1'b0;
  logic [15:0] m_count = 16'h0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_f(input logic [31:0] a);
    case (a)
      32'h0000_0000: rom_f = 32'h2008_0005;
      32'h0000_0004: rom_f = 32'h0109_5020;
      32'h0000_0008: rom_f = 32'h1234_5678;
      32'h0000_000C: rom_f = 32'hFFFF_FFFF;
      default:       rom_f = {a[15:0] ^ 16'hA5A5, ~a[15:0]};
    endcase
  endfunction

  assign mem_rdata  = rom_f(mem_addr);
  assign mem_rdata0 = rom_f(mem_addr0);

  fetch_sequencer #(.RESET_PC(32'h0), .PC_STEP(4), .MEM_LAT(LAT), .HALT_WORD(32'hFFFF_FFFF)) dut (
    .i_clk(clk), .i_reset(reset), .o_mem_addr(mem_addr), .i_mem_rdata(mem_rdata),
    .o_inst(inst), .o_inst_valid(inst_valid), .i_inst_ready(inst_ready),
    .i_redirect(redirect), .i_redirect_pc(redirect_pc), .o_pc(pc), .o_halt(halt),
    .o_fetch_count(fetch_count));

  fetch_sequencer #(.RESET_PC(32'h0), .PC_STEP(4), .MEM_LAT(0), .HALT_WORD(32'hFFFF_FFFF)) dut0 (
    .i_clk(clk), .i_reset(reset0), .o_mem_addr(mem_addr0), .i_mem_rdata(mem_rdata0),
    .o_inst(inst0), .o_inst_valid(inst_valid0), .i_inst_ready(1'b1),
    .i_redirect(1'b0), .i_redirect_pc(32'h0), .o_pc(pc0), .o_halt(halt0),
    .o_fetch_count(fetch_count0));

  // One clock edge; the model applies the fetch rules to the inputs seen at the edge.
  task automatic tick();
    @(posedge clk);
    e++;
    if (reset) begin
      m_pc = 32'h0; m_valid = 1'b0; m_halt = 1'b0; m_inst = 32'h0; m_count = 16'h0;
      m_ready_at = e + LAT + 1;
    end else if (redirect) begin
      m_pc = redirect_pc & 32'hFFFF_FFFC; m_valid = 1'b0; m_halt = 1'b0;
      m_ready_at = e + LAT + 1;
    end else if (m_valid && inst_ready) begin
      m_pc = m_pc + 32'd4; m_count = m_count + 16'd1; m_valid = 1'b0;
      m_ready_at = e + LAT + 1;
    end else if (!m_valid && !m_halt && e == m_ready_at) begin
      if (rom_f(m_pc) == 32'hFFFF_FFFF) m_halt = 1'b1;
      else begin m_inst = rom_f(m_pc); m_valid = 1'b1; end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b1;
    tick(); tick();
    n_chk++; if (pc !== 32'h0 || inst_valid !== 1'b0 || halt !== 1'b0 || inst !== 32'h0 || fetch_count !== 16'h0)
      $display("FAIL reset_state: pc=%h valid=%b halt=%b inst=%h cnt=%0d, want 0/0/0/0/0", pc, inst_valid, halt, inst, fetch_count);
    else n_pass++;
    reset = 1'b0;
    tick();
    n_chk++; if (inst_valid !== 1'b0) $display("FAIL first_lat_early: valid=%b want 0", inst_valid); else n_pass++;
    tick();
    n_chk++; if (inst_valid !== 1'b1 || inst !== 32'h2008_0005 || pc !== 32'h0)
      $display("FAIL first_fetch: valid=%b inst=%h pc=%h want 1/20080005/0", inst_valid, inst, pc);
    else n_pass++;
    tick();
    n_chk++; if (pc !== 32'h4 || fetch_count !== 16'd1 || inst_valid !== 1'b0)
      $display("FAIL first_accept: pc=%h cnt=%0d valid=%b want 4/1/0", pc, fetch_count, inst_valid);
    else n_pass++;
  endtask

  task automatic test_stall();
    inst_ready = 1'b0;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      n_chk++; if (inst_valid !== 1'b1 || inst !== 32'h0109_5020 || pc !== 32'h4)
        $display("FAIL stall_hold: valid=%b inst=%h pc=%h want 1/01095020/4", inst_valid, inst, pc);
      else n_pass++;
    end
    inst_ready = 1'b1;
    tick();
    n_chk++; if (pc !== 32'h8 || inst_valid !== 1'b0 || fetch_count !== 16'd2)
      $display("FAIL stall_release: pc=%h valid=%b cnt=%0d want 8/0/2", pc, inst_valid, fetch_count);
    else n_pass++;
  endtask

  task automatic test_redirect();
    inst_ready = 1'b0;
    tick(); tick();
    n_chk++; if (inst_valid !== 1'b1 || pc !== 32'h8) $display("FAIL redir_pre: valid=%b pc=%h want 1/8", inst_valid, pc); else n_pass++;
    redirect = 1'b1; redirect_pc = 32'h0000_0042; inst_ready = 1'b1;
    tick();
    n_chk++; if (pc !== 32'h40 || inst_valid !== 1'b0 || fetch_count !== 16'd2)
      $display("FAIL redir_take: pc=%h valid=%b cnt=%0d want 40/0/2", pc, inst_valid, fetch_count);
    else n_pass++;
    redirect = 1'b0; inst_ready = 1'b0;
    tick();
    n_chk++; if (inst_valid !== 1'b0) $display("FAIL redir_lat: valid=%b want 0", inst_valid); else n_pass++;
    tick();
    n_chk++; if (inst_valid !== 1'b1 || inst !== rom_f(32'h40))
      $display("FAIL redir_fetch: valid=%b inst=%h want 1/%h", inst_valid, inst, rom_f(32'h40));
    else n_pass++;
  endtask

  task automatic test_halt();
    redirect = 1'b1; redirect_pc = 32'h0000_000C;
    tick();
    redirect = 1'b0;
    tick(); tick();
    for (int i = 0; i < 20; i++) begin
      inst_ready = 1'($urandom_range(0, 1));
      n_chk++; if (halt !== 1'b1 || inst_valid !== 1'b0 || pc !== 32'hC || mem_addr !== 32'hC)
        $display("FAIL halted: halt=%b valid=%b pc=%h addr=%h want 1/0/c/c", halt, inst_valid, pc, mem_addr);
      else n_pass++;
      tick();
    end
    redirect = 1'b1; redirect_pc = 32'h0;
    tick();
    n_chk++; if (halt !== 1'b0 || pc !== 32'h0) $display("FAIL halt_resume: halt=%b pc=%h want 0/0", halt, pc); else n_pass++;
    redirect = 1'b0; inst_ready = 1'b0;
    tick(); tick();
    n_chk++; if (inst_valid !== 1'b1 || inst !== 32'h2008_0005)
      $display("FAIL halt_refetch: valid=%b inst=%h want 1/20080005", inst_valid, inst);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [15:0] c_before;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0; inst_ready = 1'b0;
    tick(); tick();
    n_chk++; if (inst_valid !== 1'b1 || pc !== 32'hFFFF_FFFC || inst !== rom_f(32'hFFFF_FFFC))
      $display("FAIL wrap_hold: valid=%b pc=%h inst=%h want 1/fffffffc/%h", inst_valid, pc, inst, rom_f(32'hFFFF_FFFC));
    else n_pass++;
    c_before = m_count;
    inst_ready = 1'b1;
    tick();
    n_chk++; if (pc !== 32'h0 || fetch_count !== c_before + 16'd1)
      $display("FAIL wrap_pc: pc=%h cnt=%0d want 0/%0d", pc, fetch_count, c_before + 16'd1);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    redirect = 1'b1; redirect_pc = 32'h20;
    tick();
    redirect = 1'b0; reset = 1'b1;
    tick();
    n_chk++; if (pc !== 32'h0 || inst_valid !== 1'b0 || halt !== 1'b0 || inst !== 32'h0 || fetch_count !== 16'h0)
      $display("FAIL reset_wait: pc=%h valid=%b halt=%b inst=%h cnt=%0d want all 0", pc, inst_valid, halt, inst, fetch_count);
    else n_pass++;
    reset = 1'b0; inst_ready = 1'b0;
    tick(); tick();
    n_chk++; if (inst_valid !== 1'b1 || pc !== 32'h0 || inst !== 32'h2008_0005)
      $display("FAIL reset_refetch: valid=%b pc=%h inst=%h want 1/0/20080005", inst_valid, pc, inst);
    else n_pass++;
    reset = 1'b1;
    tick();
    n_chk++; if (pc !== 32'h0 || inst_valid !== 1'b0 || inst !== 32'h0 || fetch_count !== 16'h0)
      $display("FAIL reset_hold: pc=%h valid=%b inst=%h cnt=%0d want all 0", pc, inst_valid, inst, fetch_count);
    else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      inst_ready  = ($urandom_range(0, 9) < 7);
      redirect    = ($urandom_range(0, 29) == 0);
      redirect_pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                : 32'($urandom_range(0, 95));
      reset       = ($urandom_range(0, 199) == 0);
      tick();
      n_chk++; if (pc !== m_pc || mem_addr !== m_pc || inst_valid !== m_valid || halt !== m_halt ||
                   fetch_count !== m_count || inst !== m_inst)
        $display("FAIL random cyc %0d: pc=%h valid=%b halt=%b cnt=%0d inst=%h want %h/%b/%b/%0d/%h",
                 i, pc, inst_valid, halt, fetch_count, inst, m_pc, m_valid, m_halt, m_count, m_inst);
      else n_pass++;
    end
    reset = 1'b0; redirect = 1'b0;
  endtask

  task automatic test_back_to_back();
    reset0 = 1'b1;
    tick();
    reset0 = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_chk++; if (inst_valid0 !== 1'(k % 2) || pc0 !== 32'(4 * (k / 2)))
        $display("FAIL b2b k=%0d: valid=%b pc=%h want %b/%h", k, inst_valid0, pc0, 1'(k % 2), 32'(4 * (k / 2)));
      else n_pass++;
    end
    n_chk++; if (fetch_count0 !== 16'd3) $display("FAIL b2b_count: cnt=%0d want 3", fetch_count0); else n_pass++;
    tick();
    n_chk++; if (halt0 !== 1'b1 || inst_valid0 !== 1'b0) $display("FAIL b2b_halt: halt=%b valid=%b want 1/0", halt0, inst_valid0); else n_pass++;
  endtask

  initial begin
    reset0 = 1'b1;
    test_reset();
    test_stall();
    test_redirect();
    test_halt();
    test_wrap();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Control FSM for the instruction-fetch datapath: owns the PC register, drives the instruction ROM address, waits a fixed ROM latency, then latches the word into an instruction register.
- Hands the instruction to decode over a valid/ready handshake and accepts branch/jump redirects.
- Stops fetching when the halt word is read.
- Sits between the instruction ROM and the decode stage; replaces a free-running PC+adder loop with a stallable, redirectable sequencer.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- PC_STEP, 4, increment applied after each accepted instruction.
- MEM_LAT, 1, ROM wait cycles before the data is sampled; legal range 0..15.
- HALT_WORD, 32'hFFFFFFFF, instruction encoding that stops fetch.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_addr  out  32  ROM address; combinationally equal to pc.
- mem_rdata  in  32  ROM data.
- inst  out  32  instruction register.
- inst_valid  out  1  inst holds an instruction not yet accepted.
- inst_ready  in  1  decode can accept inst this cycle.
- redirect  in  1  load redirect_pc and restart fetch.
- redirect_pc  in  32  redirect target.
- pc  out  32  address of the instruction being fetched or held.
- halt  out  1  halt word was read; fetch is stopped.
- fetch_count  out  16  number of accepted instructions; wraps modulo 2^16.

Behaviour:
- Reset (synchronous, overrides everything, including mid-wait or HOLD):
  - pc=RESET_PC, state=WAIT, wcnt=MEM_LAT.
  - inst=0, inst_valid=0, halt=0, fetch_count=0.
- States:
  - WAIT: address on the ROM, counting latency.
  - HOLD: inst_valid=1, waiting for decode.
  - HALTED: idle.
- WAIT:
  - If wcnt!=0: wcnt decrements.
  - If wcnt==0: sample mem_rdata.
    - mem_rdata==HALT_WORD: go to HALTED, halt<=1, inst_valid stays 0, inst unchanged.
    - Otherwise: inst<=mem_rdata, inst_valid<=1, go to HOLD.
  - Latency: the first inst_valid rises MEM_LAT+1 cycles after reset deasserts or after a redirect/advance.
- HOLD:
  - inst and pc are held stable while inst_valid=1 and there is no redirect.
  - Transfer = inst_valid & inst_ready & !redirect.
  - On transfer: pc<=pc+PC_STEP (mod 2^32; 32'hFFFFFFFC+4 wraps to 0), fetch_count+1, inst_valid<=0, wcnt<=MEM_LAT, go to WAIT.
- HALTED:
  - halt=1, inst_valid=0, pc frozen, mem_addr=pc (the halt word address).
  - inst_ready is ignored.
- Redirect:
  - Highest priority below reset; applies in every state.
  - pc <= {redirect_pc[31:2],2'b00}, inst_valid<=0, halt<=0, wcnt<=MEM_LAT, go to WAIT.
  - If it coincides with inst_ready in HOLD, the held instruction is discarded and not counted.
  - Redirect in WAIT restarts the latency count.
  - Redirect while HALTED resumes fetch.
- No combinational path from inst_ready or redirect to inst_valid; all outputs except mem_addr are registered.
- MEM_LAT=0: one cycle per WAIT; the back-to-back rate with inst_ready held high is one instruction per 2 cycles.

Test Plan:
- Reset, MEM_LAT=1, ROM[0]=0x20080005, inst_ready=1 → inst_valid rises on the 2nd edge after reset drops, inst=0x20080005, pc=0. After the accept, pc=4 and fetch_count=1.
- inst_ready=0 for 5 cycles in HOLD with ROM[4]=0x01095020 → inst_valid stays 1, inst/pc stable at 0x01095020/4. Raising ready advances pc to 8 on the next edge.
- In HOLD at pc=8, assert redirect=1, redirect_pc=0x00000042, inst_ready=1 → pc=0x40, inst_valid=0 next cycle, fetch_count unchanged. Next valid inst is ROM[0x40] after MEM_LAT+1 cycles.
- ROM[0x0C]=0xFFFFFFFF → halt=1, inst_valid never rises, pc stays 0x0C for 20 cycles. A redirect to 0 clears halt and refetches ROM[0].
- Redirect to 0xFFFFFFFC, accept → pc wraps to 0x00000000. Also drive 65536 accepts → fetch_count wraps to 0.
- Assert reset for 1 cycle while in WAIT with wcnt=1 and again while in HOLD → all outputs return to reset values on that edge, and fetch restarts at RESET_PC.
